// File: rtl/counter_scheduler.sv
// counter_scheduler: shares one external up/down counter among NUM_REQ requesters.
// A winner's job loads the counter with its start value, steps it len times
// (up or down), then reports the final count on result with a done pulse.
// Arbitration is round-robin by default; define COUNTER_SCHEDULER_FIXED_PRIO_EN
// for fixed priority where the lowest requester index always wins.
module counter_scheduler #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_dir,
    input  logic [NUM_REQ*WIDTH-1:0] req_init,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         result,
    output logic                     busy,
    output logic                     cnt_load,
    output logic [WIDTH-1:0]         cnt_init,
    output logic                     cnt_up,
    output logic                     cnt_down,
    input  logic [WIDTH-1:0]         cnt_value
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state, next_state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   owner_next;
    logic [NUM_REQ-1:0] owner_onehot;
    logic               job_dir;
    logic [LEN_W-1:0]   job_len;
    logic [LEN_W-1:0]   remain, next_remain;
    logic               accept;
    logic [WIDTH-1:0]   win_init;

    assign accept       = (state == IDLE) && (|req);
    assign owner_next   = (state == IDLE) ? win : owner;
    assign owner_onehot = NUM_REQ'(1) << owner_next;
    assign win_init     = WIDTH'(req_init >> (int'(win) * WIDTH));

    // Winner search; later (lower-priority) candidates are overwritten by earlier ones.
    always_comb begin
        win  = '0;
        cand = '0;
`ifdef COUNTER_SCHEDULER_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (req[cand]) win = cand;
        end
`else
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req[cand]) win = cand;
        end
`endif
    end

    // Next-state and step-count bookkeeping.
    always_comb begin
        next_state  = state;
        next_remain = remain;
        case (state)
            IDLE: if (|req) next_state = LOAD;
            LOAD: begin
                if (job_len != '0) begin
                    next_state  = RUN;
                    next_remain = job_len;
                end else begin
                    next_state = DONE;
                end
            end
            RUN: begin
                if (remain == LEN_W'(1)) next_state = DONE;
                else                     next_remain = remain - LEN_W'(1);
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Job parameters captured when a request is accepted; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner   <= win;
            job_dir <= req_dir[win];
            job_len <= LEN_W'(req_len >> (int'(win) * LEN_W));
        end
    end

    // State, arbitration pointer and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            remain   <= '0;
            ptr      <= IDX_W'(NUM_REQ - 1);
            grant    <= '0;
            done     <= '0;
            result   <= '0;
            busy     <= 1'b0;
            cnt_load <= 1'b0;
            cnt_init <= '0;
            cnt_up   <= 1'b0;
            cnt_down <= 1'b0;
        end else begin
            state    <= next_state;
            remain   <= next_remain;
            if (accept) ptr <= win;
            grant    <= (next_state != IDLE) ? owner_onehot : '0;
            done     <= (next_state == DONE) ? owner_onehot : '0;
            busy     <= (next_state != IDLE);
            cnt_load <= (next_state == LOAD);
            cnt_init <= (next_state == LOAD) ? win_init : '0;
            cnt_up   <= (next_state == RUN) && job_dir;
            cnt_down <= (next_state == RUN) && !job_dir;
            // The last step lands on the edge entering DONE, so the final count is read in DONE.
            if (state == DONE) result <= cnt_value;
        end
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// Scoreboard bench for counter_scheduler: directed scenarios then random traffic,
// with an external counter model driven by the scheduler's cnt_* outputs.
module tb_counter_scheduler;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_dir = '0;
    logic [31:0] req_init = '0;
    logic [31:0] req_len = '0;
    logic [3:0]  grant, done;
    logic [7:0]  result, cnt_init;
    logic [7:0]  cnt_value = '0;
    logic        busy, cnt_load, cnt_up, cnt_down;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    typedef struct {
        int         win;
        logic [7:0] init;
        logic [7:0] res;
        int         len;
        bit         dir;
        longint     t;
    } exp_t;

    exp_t sb[$];
    int   glog[$];

    counter_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(rst_n), .req(req), .req_dir(req_dir), .req_init(req_init),
        .req_len(req_len), .grant(grant), .done(done), .result(result), .busy(busy),
        .cnt_load(cnt_load), .cnt_init(cnt_init), .cnt_up(cnt_up), .cnt_down(cnt_down),
        .cnt_value(cnt_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The shared counter being scheduled.
    always @(posedge clk) begin
        if (cnt_load)      cnt_value <= cnt_init;
        else if (cnt_up)   cnt_value <= cnt_value + 8'd1;
        else if (cnt_down) cnt_value <= cnt_value - 8'd1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration: first requesting index in priority order.
    function automatic int pick(input logic [3:0] r, input int last);
        int w;
        int idx;
        w = -1;
`ifdef COUNTER_SCHEDULER_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = i + 0 * last;
            if (w < 0 && 1'(r >> idx)) w = idx;
        end
`else
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (last + i) % NUM_REQ;
            if (w < 0 && 1'(r >> idx)) w = idx;
        end
`endif
        return w;
    endfunction

    task automatic set_job(input int i, input logic d, input logic [7:0] init, input int len);
        req_dir  = (req_dir & ~(4'b1 << i)) | (4'(d) << i);
        req_init = (req_init & ~(32'hFF << (8 * i))) | (32'(init) << (8 * i));
        req_len  = (req_len & ~(32'hFF << (8 * i))) | (32'(len & 8'hFF) << (8 * i));
    endtask

    task automatic wait_grant(input int budget);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (grant == 0 && n < budget);
        if (grant == 0) begin
            checks++; errors++;
            $display("FAIL grant_timeout: no grant after %0d cycles", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < budget);
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles", budget);
        end
    endtask

    task automatic wait_grants(input int count, input int budget);
        int n;
        n = 0;
        while (glog.size() < count && n < budget) begin @(negedge clk); n++; end
        if (glog.size() < count) begin
            checks++; errors++;
            $display("FAIL grant_count_timeout: got %0d grants, want %0d", glog.size(), count);
        end
    endtask

    // Predictor: whenever the scheduler is idle with a request pending, push the job it must run.
    initial begin : predictor
        int   last;
        exp_t e;
        last = NUM_REQ - 1;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                sb.delete();
                last = NUM_REQ - 1;
            end else if (!busy && req != 0) begin
                e.win  = pick(req, last);
                last   = e.win;
                e.init = 8'(req_init >> (8 * e.win));
                e.len  = int'(8'(req_len >> (8 * e.win)));
                e.dir  = 1'(req_dir >> e.win);
                e.res  = e.dir ? e.init + 8'(e.len) : e.init - 8'(e.len);
                e.t    = cyc;
                sb.push_back(e);
            end
        end
    end

    // Monitor: compares grant/load at job start, done/steps at job end, result holding in between.
    initial begin : monitor
        logic [3:0] prev_grant;
        logic [7:0] held, res_pending;
        bit         done_prev;
        int         ups, downs;
        exp_t       e;
        prev_grant = '0; held = '0; res_pending = '0; done_prev = 0; ups = 0; downs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_grant = '0; held = '0; done_prev = 0; ups = 0; downs = 0;
                continue;
            end
            if (done_prev) held = res_pending;
            chk("result_hold", result, held);
            chk("up_down_exclusive", 64'(cnt_up & cnt_down), 0);
            if (!busy) chk("idle_quiet", {grant, done, cnt_load, cnt_up, cnt_down}, 0);
            if (grant != 0 && prev_grant == 0) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL grant_unexpected: got 0x%0h, want no job", grant);
                end else begin
                    e = sb[0];
                    chk("grant_onehot", grant, 4'b1 << e.win);
                    chk("grant_latency", cyc, e.t + 1);
                    chk("load_pulse", cnt_load, 1);
                    chk("load_value", cnt_init, e.init);
                end
                glog.push_back($clog2(grant));
                ups = 0; downs = 0;
            end
            if (cnt_up)   ups++;
            if (cnt_down) downs++;
            done_prev = 0;
            if (done != 0) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got 0x%0h, want no pulse", done);
                end else begin
                    e = sb.pop_front();
                    chk("done_owner", done, 4'b1 << e.win);
                    chk("done_latency", cyc, e.t + 2 + e.len);
                    chk("up_steps", ups, e.dir ? e.len : 0);
                    chk("down_steps", downs, e.dir ? 0 : e.len);
                    res_pending = e.res;
                    done_prev = 1;
                end
            end
            prev_grant = grant;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int exp35[5];
        #1 rst_n = 1'b0;
        #2;
        chk("reset_grant", grant, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_busy", busy, 0);
        chk("reset_load", {cnt_load, cnt_init, cnt_up, cnt_down}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Count up from 0x02 by 10.
        @(negedge clk);
        set_job(0, 1'b1, 8'h02, 10);
        req = 4'b0001;
        wait_grant(10);
        chk("up_grant", grant, 4'b0001);
        req = '0;
        wait_idle(40);
        chk("up_result", result, 8'h0C);

        // Count down from 0x03 by 5 with wrap.
        set_job(1, 1'b0, 8'h03, 5);
        req = 4'b0010;
        wait_grant(10);
        req = '0;
        wait_idle(40);
        chk("down_result", result, 8'hFE);

        // All requesting, len=1: rotation from reset.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        glog.delete();
        for (int i = 0; i < NUM_REQ; i++) set_job(i, 1'b1, 8'(i * 16), 1);
        req = 4'b1111;
        wait_grants(5, 60);
        req = '0;
        wait_idle(20);
`ifdef COUNTER_SCHEDULER_FIXED_PRIO_EN
        exp35 = '{0, 0, 0, 0, 0};
`else
        exp35 = '{0, 1, 2, 3, 0};
`endif
        if (glog.size() >= 5)
            for (int i = 0; i < 5; i++) chk($sformatf("rotation_%0d", i), glog[i], exp35[i]);

        // Zero-length job.
        set_job(2, 1'b1, 8'h04, 0);
        req = 4'b0100;
        wait_grant(10);
        req = '0;
        wait_idle(10);
        chk("zero_len_result", result, 8'h04);

        // Reset in the middle of a run abandons the job.
        set_job(0, 1'b1, 8'h10, 10);
        req = 4'b0001;
        wait_grant(10);
        req = '0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_grant", grant, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", {cnt_load, cnt_init, cnt_up, cnt_down}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        set_job(2, 1'b0, 8'h30, 3);
        req = 4'b0100;
        wait_grant(10);
        chk("post_reset_grant", grant, 4'b0100);
        req = '0;
        wait_idle(20);
        chk("post_reset_result", result, 8'h2D);

        // Owner drops request mid-run while another raises it.
        glog.delete();
        set_job(0, 1'b1, 8'h20, 6);
        req = 4'b0001;
        wait_grant(10);
        repeat (3) @(negedge clk);
        set_job(0, 1'b0, 8'h77, 33);
        set_job(1, 1'b0, 8'h05, 2);
        req = 4'b0010;
        wait_grants(2, 40);
        req = '0;
        wait_idle(20);
        if (glog.size() >= 2) begin
            chk("handover_first", glog[0], 0);
            chk("handover_second", glog[1], 1);
        end
        chk("handover_result", result, 8'h03);

        // Random traffic with inputs changing at any time.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                req = 4'($urandom_range(0, 15));
                for (int i = 0; i < NUM_REQ; i++)
                    set_job(i, 1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 9)));
            end
        end
        req = '0;
        wait_idle(100);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_scheduler.md
COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the counter data width.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters.
REQ-003 The block SHALL have parameter LEN_W, default 8, meaning the job-length field width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, NUM_REQ, per-requester job request (level).
REQ-007 The block SHALL have port req_dir, input, NUM_REQ, per-requester direction (1 = up, 0 = down).
REQ-008 The block SHALL have port req_init, input, NUM_REQ*WIDTH, per-requester start value; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port req_len, input, NUM_REQ*LEN_W, per-requester step count, packed the same way.
REQ-010 The block SHALL have port grant, output, NUM_REQ, one-hot owner of the counter.
REQ-011 The block SHALL have port done, output, NUM_REQ, one-cycle completion pulse to the owner.
REQ-012 The block SHALL have port result, output, WIDTH, final counter value of the last completed job.
REQ-013 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-014 The block SHALL have ports cnt_load (1), cnt_init (WIDTH), cnt_up (1), cnt_down (1) as outputs driving the counter's reset/init_val/up/down.
REQ-015 The block SHALL have port cnt_value, input, WIDTH, the counter's count output.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, RUN and DONE; all outputs are registered.
REQ-017 In IDLE with any req bit high, the block SHALL pick one winner and latch its dir, init and len, then move to LOAD on the next edge.
REQ-018 Arbitration SHALL be round-robin: search starts at the index after the last winner and wraps modulo NUM_REQ.
REQ-019 In LOAD, the block SHALL hold cnt_load=1 and cnt_init=latched init for exactly one cycle.
REQ-020 From LOAD, the block SHALL go to RUN if len>0, else directly to DONE.
REQ-021 In RUN, the block SHALL assert cnt_up (dir=1) or cnt_down (dir=0) for exactly len consecutive cycles, then go to DONE.
REQ-022 cnt_up and cnt_down SHALL never both be 1, and neither SHALL be 1 outside RUN.
REQ-023 In DONE, the block SHALL pulse done[winner] for one cycle, capture cnt_value into result, and return to IDLE.
REQ-024 Expected result SHALL be (init ± len) mod 2^WIDTH; wrap-around is not flagged.
REQ-025 grant[winner] SHALL be high from LOAD through DONE inclusive and zero in IDLE.
REQ-026 Latency: with req first seen in IDLE at cycle t, grant rises at t+1, done pulses at t+2+len.
REQ-027 req SHALL be sampled only in IDLE; deassertion or changes of req, req_dir, req_init or req_len during a job SHALL be ignored, and the job SHALL run to completion.
REQ-028 At least one IDLE cycle SHALL separate consecutive jobs; a req held through done SHALL be re-eligible in that IDLE cycle.
REQ-029 result SHALL hold its value until the next DONE.

Reset
REQ-030 While reset=0, the block SHALL force state=IDLE, grant=0, done=0, result=0, busy=0, cnt_load=0, cnt_init=0, cnt_up=0, cnt_down=0, and round-robin pointer=NUM_REQ-1, so requester 0 wins first.
REQ-031 Reset asserted mid-job SHALL abandon the job without a done pulse.

Configuration
REQ-032 With macro COUNTER_SCHEDULER_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins); when undefined, arbitration SHALL be round-robin per REQ-018.

Verification
REQ-033 req=0001, dir=1, init=0x02, len=10 -> grant=0001 one cycle later, cnt_up high for 10 cycles, done[0] at t+12, result=0x0C.
REQ-034 req=0010, dir=0, init=0x03, len=5 -> cnt_down high for 5 cycles, result=0xFE (wrap), no cnt_up activity.
REQ-035 req=1111 held, all len=1 -> grants in order 0001, 0010, 0100, 1000, 0001; with FIXED_PRIO_EN, grant is always 0001.
REQ-036 len=0, init=0x04 -> LOAD then DONE, no up/down pulse, result=0x04, done at t+2.
REQ-037 Reset driven low during RUN of a len=10 job -> all outputs 0 immediately, no done pulse; after release, req=0100 is granted normally.
REQ-038 Owner drops req mid-RUN while another requester raises req -> current job completes with correct result, then the other requester is granted after one IDLE cycle.
